// File: rtl/multi_cycle_cu.sv
// Multi-cycle RISC-V control unit.
// Runs FETCH -> DECODE -> EXEC -> [MEM] -> [WB] for each instruction.
// All control outputs are decoded from the current state, the registered
// instruction class and the handshake inputs. Unsupported opcodes end in a
// TRAP state that only reset can leave.
module multi_cycle_cu (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] INST,
  input  logic        IMEM_RDY,
  input  logic        DMEM_RDY,
  input  logic        BR_TAKEN,
  output logic        IMEM_REQ,
  output logic        IR_WE,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic        REG_WE,
  output logic        PC_WE,
  output logic [1:0]  PC_SEL,
  output logic [1:0]  WB_SEL,
  output logic [2:0]  ALU_INST,
  output logic        ILLEGAL,
  output logic        INSTRET
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // C_NONE doubles as the reset value and the "unsupported opcode" marker.
  typedef enum logic [3:0] {
    C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP
  } cls_t;

  state_t     r_state;
  state_t     w_next;
  cls_t       r_cls;
  cls_t       w_dec_cls;
  logic       r_started;
  logic [2:0] w_alu_code;

  // Only the opcode field steers the control unit.
  logic w_unused_inst;
  assign w_unused_inst = ^INST[31:7];

  // Classify the opcode field of the instruction register.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_dec_cls = C_NONE;
    case (INST[6:0])
      7'b0110111: w_dec_cls = C_LUI;
      7'b0010111: w_dec_cls = C_AUIPC;
      7'b1101111: w_dec_cls = C_JAL;
      7'b1100111: w_dec_cls = C_JALR;
      7'b1100011: w_dec_cls = C_BRANCH;
      7'b0000011: w_dec_cls = C_LOAD;
      7'b0100011: w_dec_cls = C_STORE;
      7'b0010011: w_dec_cls = C_OPIMM;
      7'b0110011: w_dec_cls = C_OP;
      default:    w_dec_cls = C_NONE;
    endcase
  end

  // Map the registered class onto the ALU control decoder's class code.
  always_comb begin
    w_alu_code = 3'd0;
    case (r_cls)
      C_JALR, C_LOAD, C_STORE: w_alu_code = 3'd1;
      C_OPIMM:                 w_alu_code = 3'd2;
      C_BRANCH:                w_alu_code = 3'd3;
      C_OP:                    w_alu_code = 3'd4;
      default:                 w_alu_code = 3'd0;
    endcase
  end

  // State register; reset drops straight into IDLE, so every output falls
  // without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Class captured in DECODE and held until it is overwritten by the next
  // DECODE; r_started gives one full IDLE cycle after reset release.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cls     <= C_NONE;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
      end
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    w_next   = r_state;
    IMEM_REQ = 1'b0;
    IR_WE    = 1'b0;
    DMEM_REQ = 1'b0;
    DMEM_WE  = 1'b0;
    REG_WE   = 1'b0;
    PC_WE    = 1'b0;
    PC_SEL   = 2'd0;
    WB_SEL   = 2'd0;
    ALU_INST = 3'd0;
    ILLEGAL  = 1'b0;
    INSTRET  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_started) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_RDY) begin
          IR_WE  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = (w_dec_cls == C_NONE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        ALU_INST = w_alu_code;
        case (r_cls)
          C_BRANCH: begin
            // Branches retire here; not-taken falls through to PC+4.
            PC_WE   = 1'b1;
            PC_SEL  = BR_TAKEN ? 2'd1 : 2'd0;
            INSTRET = 1'b1;
            w_next  = S_FETCH;
          end
          C_LOAD, C_STORE: w_next = S_MEM;
          default:         w_next = S_WB;
        endcase
      end
      S_MEM: begin
        ALU_INST = w_alu_code;
        DMEM_REQ = 1'b1;
        DMEM_WE  = (r_cls == C_STORE);
        if (DMEM_RDY) begin
          if (r_cls == C_STORE) begin
            PC_WE   = 1'b1;
            INSTRET = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        // rd = x0 is still written; the register file discards it.
        REG_WE  = 1'b1;
        PC_WE   = 1'b1;
        INSTRET = 1'b1;
        w_next  = S_FETCH;
        case (r_cls)
          C_LOAD:        WB_SEL = 2'd1;
          C_JAL, C_JALR: WB_SEL = 2'd2;
          C_LUI:         WB_SEL = 2'd3;
          default:       WB_SEL = 2'd0;
        endcase
        case (r_cls)
          C_JAL:   PC_SEL = 2'd1;
          C_JALR:  PC_SEL = 2'd2;
          default: PC_SEL = 2'd0;
        endcase
      end
      S_TRAP: begin
        ILLEGAL = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Self-checking bench for multi_cycle_cu.
// A transaction-level model turns (instruction, wait counts, branch outcome)
// into the expected per-cycle output sequence plus the handshake stimulus;
// every cycle of every instruction is compared against it. A table of
// directed instructions additionally checks hand-derived summary values.
module tb_multi_cycle_cu;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] INST;
  logic        IMEM_RDY, DMEM_RDY, BR_TAKEN;
  logic        IMEM_REQ, IR_WE, DMEM_REQ, DMEM_WE, REG_WE, PC_WE;
  logic [1:0]  PC_SEL, WB_SEL;
  logic [2:0]  ALU_INST;
  logic        ILLEGAL, INSTRET;

  multi_cycle_cu dut (
    .CLK(CLK), .RSTN(RSTN), .INST(INST),
    .IMEM_RDY(IMEM_RDY), .DMEM_RDY(DMEM_RDY), .BR_TAKEN(BR_TAKEN),
    .IMEM_REQ(IMEM_REQ), .IR_WE(IR_WE), .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE), .REG_WE(REG_WE), .PC_WE(PC_WE),
    .PC_SEL(PC_SEL), .WB_SEL(WB_SEL), .ALU_INST(ALU_INST),
    .ILLEGAL(ILLEGAL), .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic [2:0] alu_inst;
    logic       illegal;
    logic       instret;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    int          iw;
    int          dw;
    bit          br;
    int          lat;
    int          alu;
    int          n_reg;
    int          wb;
    int          pc;
    int          n_imem;
    int          n_dmem;
    int          n_dwe;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Expected trace: one entry per cycle.
  outs_t       exp_q[$];
  logic        st_irdy[$], st_drdy[$], st_br[$];
  logic [31:0] st_inst[$];

  // Observations gathered while a trace runs.
  int         obs_instret_at, obs_n_instret, obs_n_ir, obs_n_imem;
  int         obs_n_dmem, obs_n_dwe, obs_n_reg;
  logic [2:0] obs_alu;
  logic [1:0] obs_wb, obs_pc;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic rbit();
    return ($urandom_range(1, 0) != 0);
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.imem_req = IMEM_REQ;
    o.ir_we    = IR_WE;
    o.dmem_req = DMEM_REQ;
    o.dmem_we  = DMEM_WE;
    o.reg_we   = REG_WE;
    o.pc_we    = PC_WE;
    o.pc_sel   = PC_SEL;
    o.wb_sel   = WB_SEL;
    o.alu_inst = ALU_INST;
    o.illegal  = ILLEGAL;
    o.instret  = INSTRET;
    return o;
  endfunction

  task automatic push_cyc(input outs_t o, input logic irdy, input logic drdy,
                          input logic brv, input logic [31:0] iv);
    exp_q.push_back(o);
    st_irdy.push_back(irdy);
    st_drdy.push_back(drdy);
    st_br.push_back(brv);
    st_inst.push_back(iv);
  endtask

  // Reference model: expected cycle sequence for one instruction, starting
  // in the first fetch cycle. Inputs that the current step ignores are random.
  task automatic build_trace(input logic [31:0] inst, input int iw, input int dw, input bit br);
    logic       legal, is_mem, is_store, is_branch;
    logic [2:0] alu;
    logic [1:0] wb, pc;
    outs_t      o;
    exp_q.delete(); st_irdy.delete(); st_drdy.delete(); st_br.delete(); st_inst.delete();
    legal = 1'b1; is_mem = 1'b0; is_store = 1'b0; is_branch = 1'b0;
    alu = 3'd0; wb = 2'd0; pc = 2'd0;
    case (inst[6:0])
      7'b0110111: wb = 2'd3;                                   // LUI
      7'b0010111: ;                                            // AUIPC
      7'b1101111: begin wb = 2'd2; pc = 2'd1; end              // JAL
      7'b1100111: begin alu = 3'd1; wb = 2'd2; pc = 2'd2; end  // JALR
      7'b1100011: begin alu = 3'd3; is_branch = 1'b1; end      // BRANCH
      7'b0000011: begin alu = 3'd1; is_mem = 1'b1; wb = 2'd1; end
      7'b0100011: begin alu = 3'd1; is_mem = 1'b1; is_store = 1'b1; end
      7'b0010011: alu = 3'd2;                                  // OP-IMM
      7'b0110011: alu = 3'd4;                                  // OP
      default:    legal = 1'b0;
    endcase
    // Fetch: request held through the waits, IR written on the ready cycle.
    for (int k = 0; k < iw; k++) begin
      o = '0; o.imem_req = 1'b1;
      push_cyc(o, 1'b0, rbit(), rbit(), $urandom);
    end
    o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1;
    push_cyc(o, 1'b1, rbit(), rbit(), $urandom);
    // Decode: silent.
    o = '0;
    push_cyc(o, rbit(), rbit(), rbit(), inst);
    if (!legal) begin
      for (int k = 0; k < 4; k++) begin
        o = '0; o.illegal = 1'b1;
        push_cyc(o, rbit(), rbit(), rbit(), inst);
      end
      return;
    end
    // Execute.
    o = '0; o.alu_inst = alu;
    if (is_branch) begin
      o.pc_we = 1'b1; o.pc_sel = br ? 2'd1 : 2'd0; o.instret = 1'b1;
      push_cyc(o, rbit(), rbit(), br, inst);
      return;
    end
    push_cyc(o, rbit(), rbit(), rbit(), inst);
    // Memory access.
    if (is_mem) begin
      for (int k = 0; k < dw; k++) begin
        o = '0; o.alu_inst = alu; o.dmem_req = 1'b1; o.dmem_we = is_store;
        push_cyc(o, rbit(), 1'b0, rbit(), inst);
      end
      o = '0; o.alu_inst = alu; o.dmem_req = 1'b1; o.dmem_we = is_store;
      if (is_store) begin
        o.pc_we = 1'b1; o.instret = 1'b1;
      end
      push_cyc(o, rbit(), 1'b1, rbit(), inst);
      if (is_store) return;
    end
    // Writeback.
    o = '0; o.reg_we = 1'b1; o.pc_we = 1'b1; o.instret = 1'b1;
    o.wb_sel = wb; o.pc_sel = pc;
    push_cyc(o, rbit(), rbit(), rbit(), inst);
  endtask

  // Apply the first ncyc cycles of the trace (all when ncyc < 0), comparing
  // every cycle's outputs and gathering summary observations.
  task automatic run_trace(input string name, input int ncyc);
    int    n;
    outs_t got;
    n = (ncyc < 0 || ncyc > exp_q.size()) ? exp_q.size() : ncyc;
    obs_instret_at = 0; obs_n_instret = 0; obs_n_ir = 0; obs_n_imem = 0;
    obs_n_dmem = 0; obs_n_dwe = 0; obs_n_reg = 0;
    obs_alu = 3'd0; obs_wb = 2'd0; obs_pc = 2'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      INST     = st_inst[i];
      IMEM_RDY = st_irdy[i];
      DMEM_RDY = st_drdy[i];
      BR_TAKEN = st_br[i];
      #1;
      got = dut_outs();
      check($sformatf("%s cyc%0d outs", name, i), {17'd0, got}, {17'd0, exp_q[i]});
      if (got.instret === 1'b1) begin
        obs_n_instret++;
        if (obs_instret_at == 0) obs_instret_at = i + 1;
        obs_wb = got.wb_sel;
        obs_pc = got.pc_sel;
      end
      if (got.ir_we === 1'b1)    obs_n_ir++;
      if (got.imem_req === 1'b1) obs_n_imem++;
      if (got.dmem_req === 1'b1) obs_n_dmem++;
      if (got.dmem_we === 1'b1)  obs_n_dwe++;
      if (got.reg_we === 1'b1)   obs_n_reg++;
      if (got.alu_inst > obs_alu) obs_alu = got.alu_inst;
    end
  endtask

  // Release reset at a falling edge; the block must still be idle after the
  // first rising edge so the request appears on the second.
  task automatic reset_release(input string name);
    @(negedge CLK);
    RSTN = 1'b1;
    IMEM_RDY = rbit(); DMEM_RDY = rbit(); BR_TAKEN = rbit(); INST = $urandom;
    @(negedge CLK);
    #1;
    check({name, " idle after 1st edge"}, {17'd0, dut_outs()}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [6:0]  ops[9];
    logic [31:0] r;

    vecs[0]  = '{"ADD",    32'h002081B3, 0, 0, 1'b0, 4, 4, 1, 0, 0, 1, 0, 0};
    vecs[1]  = '{"BEQ-T",  32'h00208463, 0, 0, 1'b1, 3, 3, 0, 0, 1, 1, 0, 0};
    vecs[2]  = '{"LW-D2",  32'h0000A183, 0, 2, 1'b0, 7, 1, 1, 1, 0, 1, 3, 0};
    vecs[3]  = '{"SW-I3",  32'h0020A023, 3, 0, 1'b0, 7, 1, 0, 0, 0, 4, 1, 1};
    vecs[4]  = '{"JAL",    32'h008000EF, 0, 0, 1'b0, 4, 0, 1, 2, 1, 1, 0, 0};
    vecs[5]  = '{"JALR",   32'h000080E7, 0, 0, 1'b0, 4, 1, 1, 2, 2, 1, 0, 0};
    vecs[6]  = '{"LUI",    32'h123450B7, 0, 0, 1'b0, 4, 0, 1, 3, 0, 1, 0, 0};
    vecs[7]  = '{"AUIPC",  32'h00001097, 0, 0, 1'b0, 4, 0, 1, 0, 0, 1, 0, 0};
    vecs[8]  = '{"ADDI",   32'h00108093, 0, 0, 1'b0, 4, 2, 1, 0, 0, 1, 0, 0};
    vecs[9]  = '{"BEQ-NI", 32'h00208463, 1, 0, 1'b0, 4, 3, 0, 0, 0, 2, 0, 0};
    vecs[10] = '{"LW-I2D1",32'h0000A183, 2, 1, 1'b0, 8, 1, 1, 1, 0, 3, 2, 0};

    ops[0] = 7'b0110111; ops[1] = 7'b0010111; ops[2] = 7'b1101111;
    ops[3] = 7'b1100111; ops[4] = 7'b1100011; ops[5] = 7'b0000011;
    ops[6] = 7'b0100011; ops[7] = 7'b0010011; ops[8] = 7'b0110011;

    // Reset state.
    RSTN = 1'b0; INST = 32'h0; IMEM_RDY = 1'b1; DMEM_RDY = 1'b1; BR_TAKEN = 1'b0;
    #2;
    check("reset outs", {17'd0, dut_outs()}, 32'd0);
    @(posedge CLK);
    #1;
    check("reset outs after edge", {17'd0, dut_outs()}, 32'd0);
    reset_release("power-on");

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      build_trace(vecs[v].inst, vecs[v].iw, vecs[v].dw, vecs[v].br);
      run_trace(vecs[v].name, -1);
      check({vecs[v].name, " instret cycle"}, obs_instret_at, vecs[v].lat);
      check({vecs[v].name, " instret count"}, obs_n_instret, 1);
      check({vecs[v].name, " ir_we count"},   obs_n_ir, 1);
      check({vecs[v].name, " alu_inst"},      {29'd0, obs_alu}, vecs[v].alu);
      check({vecs[v].name, " reg_we count"},  obs_n_reg, vecs[v].n_reg);
      check({vecs[v].name, " wb_sel"},        {30'd0, obs_wb}, vecs[v].wb);
      check({vecs[v].name, " pc_sel"},        {30'd0, obs_pc}, vecs[v].pc);
      check({vecs[v].name, " imem_req cyc"},  obs_n_imem, vecs[v].n_imem);
      check({vecs[v].name, " dmem_req cyc"},  obs_n_dmem, vecs[v].n_dmem);
      check({vecs[v].name, " dmem_we cyc"},   obs_n_dwe, vecs[v].n_dwe);
    end

    // Randomized instruction stream against the model.
    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(8, 0)];
      build_trace(r, $urandom_range(3, 0), $urandom_range(3, 0), rbit());
      run_trace($sformatf("rnd%0d op%07b", t, r[6:0]), -1);
    end

    // Reset mid-MEM of a store with the request outstanding.
    build_trace(32'h0020A023, 0, 6, 1'b0);
    run_trace("SW-rst", 4);
    #2;
    RSTN = 1'b0;
    #1;
    check("mid-MEM reset dmem_req", {31'd0, DMEM_REQ}, 32'd0);
    check("mid-MEM reset dmem_we",  {31'd0, DMEM_WE}, 32'd0);
    check("mid-MEM reset outs",     {17'd0, dut_outs()}, 32'd0);
    reset_release("mid-MEM");
    build_trace(32'h002081B3, 0, 0, 1'b0);
    run_trace("ADD after rst", -1);
    check("ADD after rst instret cycle", obs_instret_at, 4);

    // Illegal opcode traps and stays trapped without retiring.
    build_trace(32'h0000007F, 0, 0, 1'b0);
    run_trace("ILLEGAL", -1);
    check("ILLEGAL instret count", obs_n_instret, 0);
    @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("trap reset outs", {17'd0, dut_outs()}, 32'd0);
    reset_release("trap");
    build_trace(32'h0020A023, 1, 1, 1'b0);
    run_trace("SW after trap", -1);
    check("SW after trap instret cycle", obs_instret_at, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/multi_cycle_cu.md
MULTI_CYCLE_CU -- requirements
Module: multi_cycle_cu

Interface
REQ-001 The block SHALL have one clock, CLK, and one asynchronous active-low reset, RSTN.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  rising-edge clock
- RSTN  in  1  async active-low reset
- INST  in  32  instruction register contents, valid from DECODE onward
- IMEM_RDY  in  1  instruction memory accepted the request and returned data
- DMEM_RDY  in  1  data memory completed the access
- BR_TAKEN  in  1  ALU compare result, valid in EXEC
- IMEM_REQ  out  1  instruction fetch request
- IR_WE  out  1  latch the instruction register
- DMEM_REQ  out  1  data access request
- DMEM_WE  out  1  data write (store)
- REG_WE  out  1  register-file write
- PC_WE  out  1  PC update
- PC_SEL  out  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR)
- WB_SEL  out  2  writeback source: 0 = ALU, 1 = mem, 2 = PC+4, 3 = imm
- ALU_INST  out  3  ALU class code to the ALU control decoder
- ILLEGAL  out  1  unsupported opcode trap
- INSTRET  out  1  one-cycle pulse per retired instruction

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP; it SHALL leave IDLE for FETCH unconditionally one cycle after reset release.
REQ-004 In FETCH, IMEM_REQ SHALL be 1 and held while IMEM_RDY = 0; in the cycle IMEM_RDY = 1, IR_WE SHALL be 1 and the next state SHALL be DECODE.
REQ-005 In DECODE, INST[6:0] SHALL be classified as LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011 or OP 0110011; any other value SHALL go to TRAP, otherwise to EXEC.
REQ-006 The class SHALL be registered in DECODE and held until the next FETCH.
REQ-007 ALU_INST SHALL be driven in EXEC and MEM only, and SHALL be 3'd0 in all other states.
- LUI, AUIPC, JAL: 0
- JALR, LOAD, STORE: 1
- OP-IMM: 2
- BRANCH: 3
- OP: 4
REQ-008 EXEC, BRANCH: PC_WE = 1; PC_SEL = 1 if BR_TAKEN, else 0; INSTRET = 1; next state FETCH.
REQ-009 EXEC, LOAD/STORE: next state MEM. EXEC, all other classes: next state WB.
REQ-010 In MEM, DMEM_REQ SHALL be 1, and DMEM_WE SHALL be 1 for STORE only; both SHALL be held while DMEM_RDY = 0.
REQ-011 In the MEM cycle with DMEM_RDY = 1: a STORE SHALL assert PC_WE with PC_SEL = 0 and INSTRET, then go to FETCH; a LOAD SHALL go to WB.
REQ-012 WB SHALL last one cycle with REG_WE = 1, PC_WE = 1, INSTRET = 1, then go to FETCH.
- WB_SEL: LOAD 1; JAL/JALR 2; LUI 3; else 0
- PC_SEL: JAL 1; JALR 2; else 0
REQ-013 REG_WE SHALL be asserted even when rd = x0; discarding that write is the register file's job.
REQ-014 With zero-wait memories, latency from entering FETCH to INSTRET SHALL be 3 cycles for BRANCH, 4 for STORE/OP/OP-IMM/U/J and 5 for LOAD; each wait cycle adds exactly 1.
REQ-015 TRAP SHALL hold ILLEGAL = 1 with all other outputs 0 until reset; INSTRET SHALL NOT pulse for the trapping instruction.
REQ-016 Every output not listed as active for a state SHALL be 0 in that state.
REQ-017 IR_WE, PC_WE, REG_WE and INSTRET SHALL each be asserted for at most one cycle per instruction.

Reset
REQ-018 RSTN = 0 SHALL immediately force IDLE, all outputs 0 and the registered class to 0, including mid-FETCH or mid-MEM with a request outstanding.
REQ-019 After RSTN rises, IMEM_REQ SHALL first assert on the second rising CLK edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD (INST = 0x002081B3), IMEM_RDY = DMEM_RDY = 1 -> ALU_INST = 4 in EXEC; REG_WE = 1, WB_SEL = 0, PC_SEL = 0 in WB; INSTRET 4 cycles after FETCH entry.
- BEQ (0x00208463), BR_TAKEN = 1 -> in EXEC: ALU_INST = 3, PC_WE = 1, PC_SEL = 1, INSTRET = 1; REG_WE never asserted; back in FETCH next cycle.
- LW (0x0000A183), DMEM_RDY low for 2 cycles -> DMEM_REQ high 3 cycles, DMEM_WE = 0, ALU_INST = 1; WB has WB_SEL = 1; INSTRET after 7 cycles.
- SW (0x0020A023), IMEM_RDY low for 3 cycles -> IMEM_REQ held 4 cycles, single IR_WE; DMEM_WE = 1 in MEM; REG_WE never asserted.
- Opcode 0x0000007F -> TRAP with ILLEGAL = 1, no INSTRET; a later RSTN pulse returns to IDLE then FETCH.
- RSTN dropped mid-MEM of a store -> DMEM_REQ and DMEM_WE fall without waiting for a clock edge; after release, IMEM_REQ asserts on the second edge.
